// File: rtl/xtea_pkg.sv
// Shared types and helpers for the dual-rail XTEA job controller.
// Widths, FSM state encodings and the dual-rail encoder.
package xtea_pkg;

  localparam int DATA_W = 64;
  localparam int KEY_W  = 128;

  typedef enum logic [1:0] {
    I_IDLE,
    I_DATA,
    I_NULL
  } in_state_t;

  typedef enum logic [1:0] {
    O_WAIT,
    O_PRES,
    O_ACK
  } out_state_t;

  // Returns {false rail, true rail}.
  function automatic logic [2*DATA_W-1:0] dr_enc(
    input logic [DATA_W-1:0] x
  );
    return {~x, x};
  endfunction

  function automatic logic [2*KEY_W-1:0] dr_enc_key(
    input logic [KEY_W-1:0] x
  );
    return {~x, x};
  endfunction

endpackage

// File: rtl/xtea_sync.sv
// Multi-flop synchronizer for one asynchronous condition bit.
// Async active-low reset clears the whole chain.
module xtea_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/xtea_dr_ctrl.sv
// Clocked job controller for the clockless dual-rail XTEA core.
// Four-phase RTZ handshakes on the input and output channels.
module xtea_dr_ctrl
  import xtea_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEY_W-1:0]  s_key,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [DATA_W-1:0] in_enc_t,
  output logic [DATA_W-1:0] in_enc_f,
  input  logic [DATA_W-1:0] in_enc_ack,
  output logic [KEY_W-1:0]  key_t,
  output logic [KEY_W-1:0]  key_f,
  input  logic [KEY_W-1:0]  key_ack,
  input  logic [DATA_W-1:0] out_enc_t,
  input  logic [DATA_W-1:0] out_enc_f,
  output logic [DATA_W-1:0] out_enc_ack,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_illegal
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

  in_state_t  istate;
  in_state_t  istate_nx;
  out_state_t ostate;
  out_state_t ostate_nx;

  logic ack_hi;
  logic ack_lo;
  logic o_cmp;
  logic o_nul;
  logic ack_hi_s;
  logic ack_lo_s;
  logic o_cmp_s;
  logic o_nul_s;

  logic          run;
  logic          accept;
  logic          grab;
  logic          hand;
  logic          done;
  logic          out_ack;
  logic          iwait;
  logic          owait;
  logic [CW-1:0] icnt;
  logic [CW-1:0] ocnt;

  // Each condition only moves one way within a phase,
  // so reducing before synchronizing cannot glitch.
  assign ack_hi = (&in_enc_ack) & (&key_ack);
  assign ack_lo = ~(|in_enc_ack) & ~(|key_ack);
  assign o_cmp  = &(out_enc_t | out_enc_f);
  assign o_nul  = ~(|(out_enc_t | out_enc_f));

  xtea_sync #(.STAGES(SYNC_STAGES)) u_sync_ack_hi (
    .clk   (clk),
    .reset (reset),
    .d     (ack_hi),
    .q     (ack_hi_s)
  );

  xtea_sync #(.STAGES(SYNC_STAGES)) u_sync_ack_lo (
    .clk   (clk),
    .reset (reset),
    .d     (ack_lo),
    .q     (ack_lo_s)
  );

  xtea_sync #(.STAGES(SYNC_STAGES)) u_sync_o_cmp (
    .clk   (clk),
    .reset (reset),
    .d     (o_cmp),
    .q     (o_cmp_s)
  );

  xtea_sync #(.STAGES(SYNC_STAGES)) u_sync_o_nul (
    .clk   (clk),
    .reset (reset),
    .d     (o_nul),
    .q     (o_nul_s)
  );

  // run keeps s_ready low while reset is held.
  assign s_ready     = run & (istate == I_IDLE) & ~busy;
  assign accept      = s_valid & s_ready;
  assign out_enc_ack = {DATA_W{out_ack}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      istate <= I_IDLE;
      ostate <= O_WAIT;
      run    <= 1'b0;
    end else begin
      istate <= istate_nx;
      ostate <= ostate_nx;
      run    <= 1'b1;
    end
  end

  always_comb begin
    istate_nx = istate;
    unique case (istate)
      I_IDLE: if (accept) istate_nx = I_DATA;
      I_DATA: if (ack_hi_s) istate_nx = I_NULL;
      I_NULL: if (ack_lo_s) istate_nx = I_IDLE;
      default: istate_nx = I_IDLE;
    endcase
  end

  always_comb begin
    ostate_nx = ostate;
    grab      = 1'b0;
    hand      = 1'b0;
    done      = 1'b0;
    unique case (ostate)
      O_WAIT: begin
        if (busy && o_cmp_s) begin
          ostate_nx = O_PRES;
          grab      = 1'b1;
        end
      end
      O_PRES: begin
        if (m_ready) begin
          ostate_nx = O_ACK;
          hand      = 1'b1;
        end
      end
      O_ACK: begin
        if (o_nul_s) begin
          ostate_nx = O_WAIT;
          done      = 1'b1;
        end
      end
      default: ostate_nx = O_WAIT;
    endcase
  end

  // Rails are registered directly so the core never sees a glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_enc_t <= '0;
      in_enc_f <= '0;
      key_t    <= '0;
      key_f    <= '0;
    end else if (accept) begin
      {in_enc_f, in_enc_t} <= dr_enc(s_data);
      {key_f, key_t}       <= dr_enc_key(s_key);
    end else if (istate == I_DATA && ack_hi_s) begin
      in_enc_t <= '0;
      in_enc_f <= '0;
      key_t    <= '0;
      key_f    <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      out_ack     <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (accept) busy <= 1'b1;
      else if (done) busy <= 1'b0;
      if (grab) begin
        m_data  <= out_enc_t;
        m_valid <= 1'b1;
        if (|(out_enc_t & out_enc_f)) err_illegal <= 1'b1;
      end
      if (hand) begin
        m_valid <= 1'b0;
        out_ack <= 1'b1;
      end
      if (done) out_ack <= 1'b0;
    end
  end

  // O_PRES waits on the bus consumer, not the core, so it is not timed.
  assign iwait = (istate == I_DATA) | (istate == I_NULL);
  assign owait = busy & ((ostate == O_WAIT) | (ostate == O_ACK));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icnt        <= '0;
      ocnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (!iwait || istate_nx != istate) icnt <= '0;
      else if (icnt != TMO) icnt <= icnt + 1'b1;
      if (!owait || ostate_nx != ostate) ocnt <= '0;
      else if (ocnt != TMO) ocnt <= ocnt + 1'b1;
      if (icnt == TMO || ocnt == TMO) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xtea_dr_ctrl.sv
// Bench for xtea_dr_ctrl with a behavioural dual-rail XTEA core.
// Scoreboard compares m_data against a plain XTEA reference.
module tb_xtea_dr_ctrl;

  localparam int SS  = 2;
  localparam int TMO = 4096;
  localparam int LIM = 3000;

  logic         clk;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [63:0]  s_data;
  logic [127:0] s_key;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  m_data;
  logic [63:0]  in_enc_t;
  logic [63:0]  in_enc_f;
  logic [63:0]  in_enc_ack;
  logic [127:0] key_t;
  logic [127:0] key_f;
  logic [127:0] key_ack;
  logic [63:0]  out_enc_t;
  logic [63:0]  out_enc_f;
  logic [63:0]  out_enc_ack;
  logic         busy;
  logic         err_timeout;
  logic         err_illegal;

  xtea_dr_ctrl #(
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_key       (s_key),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .in_enc_t    (in_enc_t),
    .in_enc_f    (in_enc_f),
    .in_enc_ack  (in_enc_ack),
    .key_t       (key_t),
    .key_f       (key_f),
    .key_ack     (key_ack),
    .out_enc_t   (out_enc_t),
    .out_enc_f   (out_enc_f),
    .out_enc_ack (out_enc_ack),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cmp_idx = 0;

  bit mr_rand = 0;
  bit noack   = 0;
  bit ill     = 0;
  int dly_max = 20;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  function automatic logic [63:0] xtea(
    input logic [127:0] k,
    input logic [63:0]  p
  );
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] s;
    logic [31:0] kw[4];
    kw[0] = k[127:96];
    kw[1] = k[95:64];
    kw[2] = k[63:32];
    kw[3] = k[31:0];
    v0 = p[63:32];
    v1 = p[31:0];
    s  = 32'h0;
    for (int r = 0; r < 32; r++) begin
      v0 = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + kw[s[1:0]]));
      s  = s + 32'h9E3779B9;
      v1 = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + kw[s[12:11]]));
    end
    return {v0, v1};
  endfunction

  // Behavioural core: input side acks, output side produces ciphertext.
  int          rs_i;
  int          rs_o;
  int          di;
  int          dq;
  logic [63:0] ct_cur;
  logic [63:0] ct_pend[$];

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      rs_i       <= 0;
      rs_o       <= 0;
      di         <= 0;
      dq         <= 0;
      ct_cur     <= '0;
      in_enc_ack <= '0;
      key_ack    <= '0;
      out_enc_t  <= '0;
      out_enc_f  <= '0;
      ct_pend.delete();
    end else begin
      case (rs_i)
        0: if ((&(in_enc_t | in_enc_f)) && (&(key_t | key_f))) begin
          if (!noack) ct_pend.push_back(xtea(key_t, in_enc_t));
          di   <= int'($urandom_range(0, dly_max));
          rs_i <= 1;
        end
        1: if (di == 0) begin
          in_enc_ack <= '1;
          key_ack    <= noack ? {1'b0, {127{1'b1}}} : '1;
          rs_i       <= 2;
        end else di <= di - 1;
        2: if (!(|{in_enc_t, in_enc_f, key_t, key_f})) begin
          di   <= int'($urandom_range(0, dly_max));
          rs_i <= 3;
        end
        3: if (di == 0) begin
          in_enc_ack <= '0;
          key_ack    <= '0;
          rs_i       <= 0;
        end else di <= di - 1;
        default: ;
      endcase
      case (rs_o)
        0: if (ct_pend.size() != 0) begin
          ct_cur <= ct_pend.pop_front();
          dq     <= int'($urandom_range(0, dly_max));
          rs_o   <= 1;
        end
        1: if (dq == 0) begin
          out_enc_t <= ct_cur | (ill ? 64'h20 : 64'h0);
          out_enc_f <= ~ct_cur | (ill ? 64'h20 : 64'h0);
          rs_o      <= 2;
        end else dq <= dq - 1;
        2: if (&out_enc_ack) begin
          dq   <= int'($urandom_range(0, dly_max));
          rs_o <= 3;
        end
        3: if (dq == 0) begin
          out_enc_t <= '0;
          out_enc_f <= '0;
          rs_o      <= 4;
        end else dq <= dq - 1;
        4: if (!(|out_enc_ack)) rs_o <= 0;
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (reset && m_valid && m_ready) got_q.push_back(m_data);
  end

  task automatic check(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mr_rand) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_job(
    input logic [63:0]  pt,
    input logic [127:0] k,
    input logic [63:0]  ct,
    input bit           push
  );
    int t = 0;
    s_valid = 1'b1;
    s_data  = pt;
    s_key   = k;
    while (!s_ready && t < LIM) begin
      tick();
      t++;
    end
    if (!s_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_wait: s_ready low for %0d cycles", t);
    end else begin
      tick();
      if (push) exp_q.push_back(ct);
    end
    s_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int          t = 0;
    logic [63:0] g;
    while (!(got_q.size() >= exp_q.size() && s_ready) && t < LIM) begin
      tick();
      t++;
    end
    n_tests++;
    if (t >= LIM) begin
      n_fail++;
      $display("FAIL %s_drain: no completion after %0d cycles", nm, t);
    end
    for (int i = cmp_idx; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      check(nm, g, exp_q[i]);
    end
    check({nm, "_count"}, got_q.size(), exp_q.size());
    cmp_idx = exp_q.size();
  endtask

  typedef struct {
    logic [127:0] key;
    logic [63:0]  pt;
    logic [63:0]  ct;
  } vec_t;

  vec_t         vecs[6];
  logic [63:0]  pt;
  logic [127:0] k;
  logic [63:0]  d0;
  int           acc;
  int           bad;
  int           t;

  initial begin
    vecs[0] = '{128'h0, 64'h0, 64'hDEE9D4D8F7131ED9};
    for (int i = 1; i < 6; i++) begin
      vecs[i].key = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].pt  = {$urandom(), $urandom()};
      vecs[i].ct  = xtea(vecs[i].key, vecs[i].pt);
    end

    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_key   = '0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m", {m_valid, m_data}, 0);
    check("rst_in_rails", {in_enc_t, in_enc_f}, 0);
    check("rst_key_rails", |{key_t, key_f}, 0);
    check("rst_misc", {busy, err_timeout, err_illegal, out_enc_ack}, 0);
    reset = 1'b1;
    tick();
    tick();
    check("idle_ready", s_ready, 1);

    // Known vector, with the rail image one cycle after accept.
    send_job(vecs[0].pt, vecs[0].key, vecs[0].ct, 1);
    check("t1_in_f", in_enc_f, {64{1'b1}});
    check("t1_key_f", key_f, {128{1'b1}});
    check("t1_in_t", in_enc_t, 0);
    check("t1_key_t", key_t, 0);
    check("t1_busy", {busy, s_ready}, 2'b10);
    drain("t1_ct");
    check("t1_rails", |{in_enc_t, in_enc_f, key_t, key_f, out_enc_t, out_enc_f}, 0);
    check("t1_acks", {|in_enc_ack, |key_ack, |out_enc_ack, busy}, 0);

    for (int i = 1; i < 6; i++) begin
      dly_max = i * 4;
      send_job(vecs[i].pt, vecs[i].key, vecs[i].ct, 1);
      drain("vec_ct");
    end
    dly_max = 20;

    // s_valid held with one job: exactly three accepts, never while busy.
    pt = {$urandom(), $urandom()};
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    s_valid = 1'b1;
    s_data  = pt;
    s_key   = k;
    acc = 0;
    bad = 0;
    t   = 0;
    while (acc < 3 && t < 3 * LIM) begin
      if (s_ready && busy) bad++;
      if (s_ready) begin
        acc++;
        exp_q.push_back(xtea(k, pt));
      end
      tick();
      t++;
    end
    s_valid = 1'b0;
    check("t2_accepts", acc, 3);
    check("t2_ready_busy", bad, 0);
    drain("t2_ct");

    // Consumer stall: data held, no ack to the core until m_ready.
    m_ready = 1'b0;
    pt = {$urandom(), $urandom()};
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_job(pt, k, xtea(k, pt), 1);
    t = 0;
    while (!m_valid && t < LIM) begin
      tick();
      t++;
    end
    check("t3_m_valid", m_valid, 1);
    d0  = m_data;
    bad = 0;
    repeat (50) begin
      tick();
      if (m_data !== d0 || !m_valid || out_enc_ack !== 64'h0) bad++;
    end
    check("t3_stall", bad, 0);
    m_ready = 1'b1;
    tick();
    check("t3_ack", {m_valid, out_enc_ack}, {1'b0, {64{1'b1}}});
    drain("t3_ct");

    // Random jobs with random consumer backpressure.
    mr_rand = 1;
    for (int j = 0; j < 20; j++) begin
      pt = {$urandom(), $urandom()};
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      repeat ($urandom_range(0, 3)) tick();
      send_job(pt, k, xtea(k, pt), 1);
    end
    drain("rnd_ct");
    mr_rand = 0;
    m_ready = 1'b1;

    // Illegal t=f=1 on bit 5: flagged, handshake still finishes.
    check("pre_illegal", err_illegal, 0);
    ill = 1;
    pt = {$urandom(), $urandom()};
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_job(pt, k, xtea(k, pt) | 64'h20, 1);
    drain("t5_ct");
    ill = 0;
    check("t5_illegal", err_illegal, 1);
    check("t5_done", {busy, |out_enc_ack}, 0);

    // Missing key_ack[127]: timeout, input side stuck in data phase.
    check("pre_timeout", err_timeout, 0);
    noack = 1;
    send_job(pt, k, 64'h0, 0);
    repeat (4000) tick();
    check("t4_early", err_timeout, 0);
    repeat (TMO - 4000 + SS + 3) tick();
    check("t4_timeout", err_timeout, 1);
    check("t4_hold_in", &(in_enc_t | in_enc_f), 1);
    check("t4_hold_key", &(key_t | key_f), 1);
    check("t4_ready", s_ready, 0);
    reset = 1'b0;
    tick();
    tick();
    noack = 0;
    reset = 1'b1;
    tick();
    tick();
    check("t4_clear", {err_timeout, err_illegal, busy, s_ready}, 4'b0001);

    // Reset in the data phase clears outputs asynchronously.
    dly_max = 20;
    send_job(pt, k, 64'h0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rails", |{in_enc_t, in_enc_f, key_t, key_f}, 0);
    check("t6_outs", {busy, s_ready, m_valid, m_data, out_enc_ack}, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    pt = {$urandom(), $urandom()};
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_job(pt, k, xtea(k, pt), 1);
    drain("t6_ct");
    check("t6_errs", {err_timeout, err_illegal}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
